// File: rtl/imem_loader.sv
// imem_loader: loads a framed program image from a byte stream into
// instruction memory. The core is held in reset for the whole load. It is
// released only after the checksum byte matches.
// Frame layout: COUNT_LO, COUNT_HI, 4*N little-endian payload bytes, CHK.
// CHK is the XOR of the payload bytes.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal word count: the header may fill memory exactly.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_t              state_reg;
    state_t              state_next;
    logic [15:0]         count_reg;
    logic [ADDR_WIDTH:0] word_cnt_reg;
    logic [1:0]          lane_reg;
    logic [7:0]          xor_reg;
    logic [7:0]          lane_bytes [0:2];

    logic        accept;
    logic        start_load;
    logic        word_fire;
    logic        last_word;
    logic [15:0] hdr_count;

    assign accept     = byte_valid && byte_ready;
    assign start_load = start && (state_reg == S_IDLE || state_reg == S_DONE ||
                                  state_reg == S_ERR);
    assign hdr_count  = {byte_data, count_reg[7:0]};
    assign word_fire  = accept && (state_reg == S_DATA) && (lane_reg == 2'd3);
    // The word being written now is the final one of the image.
    assign last_word  = ({{(16-ADDR_WIDTH){1'b0}}, word_cnt_reg} + 17'd1) ==
                        {1'b0, count_reg};

    // byte_ready is decoded straight from the state so the source sees it
    // in the first cycle of each byte-consuming state.
    always_comb begin
        byte_ready = (state_reg == S_HDR_LO) || (state_reg == S_HDR_HI) ||
                     (state_reg == S_DATA)   || (state_reg == S_CHK);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode for the frame parser.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    state_next = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    if ({1'b0, hdr_count} > MAX_WORDS) begin
                        state_next = S_ERR;
                    end else if (hdr_count == 16'd0) begin
                        state_next = S_CHK;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_fire && last_word) begin
                    state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_next = (byte_data == xor_reg) ? S_DONE : S_ERR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Header count, word counter, lane counter and running checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg    <= '0;
            word_cnt_reg <= '0;
            lane_reg     <= '0;
            xor_reg      <= '0;
        end else begin
            if (start_load) begin
                word_cnt_reg <= '0;
                lane_reg     <= '0;
                xor_reg      <= '0;
            end
            if (accept && state_reg == S_HDR_LO) begin
                count_reg[7:0] <= byte_data;
            end
            if (accept && state_reg == S_HDR_HI) begin
                count_reg[15:8] <= byte_data;
            end
            if (accept && state_reg == S_DATA) begin
                lane_reg <= lane_reg + 2'd1;
                xor_reg  <= xor_reg ^ byte_data;
            end
            if (word_fire) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
        end
    end

    // Capture the three lower byte lanes. The top lane comes straight
    // from byte_data when the word is written.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            // Latch this lane's byte when it arrives.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lane_bytes[gi] <= '0;
                end else if (accept && state_reg == S_DATA &&
                             lane_reg == 2'(gi)) begin
                    lane_bytes[gi] <= byte_data;
                end
            end
        end
    endgenerate

    // Registered memory write port. Address and data hold until the next write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= word_fire;
            if (word_fire) begin
                imem_addr  <= word_cnt_reg[ADDR_WIDTH-1:0];
                imem_wdata <= {byte_data, lane_bytes[2], lane_bytes[1], lane_bytes[0]};
            end
        end
    end

    // Status outputs follow the state being entered, so they update one
    // cycle after the deciding byte or start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            core_hold <= (state_next != S_DONE);
            done      <= (state_next == S_DONE);
            error     <= (state_next == S_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. A negedge monitor records memory writes.
// Each scenario task checks its own results inline.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] words_q[$];
    logic [7:0]  frame_q[$];

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
        .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write strobe.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int t;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL byte_ready_timeout actual=%b required=1", byte_ready);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic make_frame(input bit bad_chk);
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        frame_q.delete();
        n = 16'(words_q.size());
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        x = 8'h00;
        foreach (words_q[i]) begin
            w = words_q[i];
            for (int k = 0; k < 4; k++) begin
                frame_q.push_back(w[8*k +: 8]);
                x = x ^ w[8*k +: 8];
            end
        end
        frame_q.push_back(bad_chk ? 8'h00 : x);
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frame_q[i]) send_byte(frame_q[i], max_gap);
    endtask

    task automatic test_reset();
        checks++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL reset_byte_ready actual=%b required=0", byte_ready); end
        checks++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we actual=%b required=0", imem_we); end
        checks++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL reset_imem_addr actual=%h required=00", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin fails++; $display("FAIL reset_imem_wdata actual=%h required=0", imem_wdata); end
        checks++; if (core_hold !== 1'b1) begin fails++; $display("FAIL reset_core_hold actual=%b required=1", core_hold); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done actual=%b required=0", done); end
        checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error actual=%b required=0", error); end
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_good_load();
        wa_q.delete(); wd_q.delete();
        words_q = '{32'h00500093, 32'h00A00113};
        make_frame(1'b0);
        checks++; if (frame_q[10] !== 8'h71) begin fails++; $display("FAIL good_chk_byte actual=%h required=71", frame_q[10]); end
        pulse_start();
        checks++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL good_ready_after_start actual=%b required=1", byte_ready); end
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], 0);
            if (i == 5) begin
                checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h00500093) begin
                    fails++; $display("FAIL good_write0_timing actual=%b/%h/%h required=1/00/00500093", imem_we, imem_addr, imem_wdata);
                end
            end
            if (i == 6) begin
                checks++; if (imem_we !== 1'b0 || imem_addr !== 8'd0 || imem_wdata !== 32'h00500093) begin
                    fails++; $display("FAIL good_write0_hold actual=%b/%h/%h required=0/00/00500093", imem_we, imem_addr, imem_wdata);
                end
            end
        end
        checks++; if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL good_status actual=%b%b%b required=100 (done,hold,err)", done, core_hold, error);
        end
        checks++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL good_ready_done actual=%b required=0", byte_ready); end
        checks++; if (wa_q.size() != 2) begin fails++; $display("FAIL good_write_count actual=%0d required=2", wa_q.size()); end
        else begin
            checks++; if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'h00500093) begin fails++; $display("FAIL good_w0 actual=%h:%h required=00:00500093", wa_q[0], wd_q[0]); end
            checks++; if (wa_q[1] !== 8'd1 || wd_q[1] !== 32'h00A00113) begin fails++; $display("FAIL good_w1 actual=%h:%h required=01:00a00113", wa_q[1], wd_q[1]); end
        end
        $display("test_good_load: N=2 frame, writes=%0d done=%b", wa_q.size(), done);
    endtask

    task automatic test_bad_chk();
        wa_q.delete(); wd_q.delete();
        words_q = '{32'h00500093, 32'h00A00113};
        make_frame(1'b1);
        pulse_start();
        checks++; if (core_hold !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL bad_restart actual=hold%b done%b required=hold1 done0", core_hold, done); end
        send_frame(0);
        checks++; if (error !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL bad_status actual=%b%b%b required=011 (done,hold,err)", done, core_hold, error);
        end
        checks++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL bad_ready actual=%b required=0", byte_ready); end
        checks++; if (wa_q.size() != 2) begin fails++; $display("FAIL bad_write_count actual=%0d required=2", wa_q.size()); end
        $display("test_bad_chk: error=%b writes=%0d", error, wa_q.size());
    endtask

    task automatic test_zero_count();
        wa_q.delete(); wd_q.delete();
        words_q.delete();
        make_frame(1'b0);
        pulse_start();
        checks++; if (error !== 1'b0) begin fails++; $display("FAIL zero_error_cleared actual=%b required=0", error); end
        send_frame(0);
        checks++; if (done !== 1'b1 || core_hold !== 1'b0) begin fails++; $display("FAIL zero_status actual=done%b hold%b required=done1 hold0", done, core_hold); end
        checks++; if (wa_q.size() != 0) begin fails++; $display("FAIL zero_writes actual=%0d required=0", wa_q.size()); end
        $display("test_zero_count: done=%b writes=%0d", done, wa_q.size());
    endtask

    task automatic test_oversize();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        checks++; if (error !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL oversize_status actual=%b%b%b required=011 (done,hold,err)", done, core_hold, error);
        end
        checks++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL oversize_ready actual=%b required=0", byte_ready); end
        checks++; if (wa_q.size() != 0) begin fails++; $display("FAIL oversize_writes actual=%0d required=0", wa_q.size()); end
        $display("test_oversize: N=257 error=%b", error);
    endtask

    task automatic test_full_memory();
        wa_q.delete(); wd_q.delete();
        words_q.delete();
        for (int i = 0; i < 256; i++) words_q.push_back($urandom);
        make_frame(1'b0);
        pulse_start();
        send_frame(2);
        checks++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL full_status actual=done%b err%b required=done1 err0", done, error); end
        checks++; if (wa_q.size() != 256) begin fails++; $display("FAIL full_write_count actual=%0d required=256", wa_q.size()); end
        else begin
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (wa_q[i] !== 8'(i) || wd_q[i] !== words_q[i]) begin
                    fails++; $display("FAIL full_write_%0d actual=%h:%h required=%h:%h", i, wa_q[i], wd_q[i], 8'(i), words_q[i]);
                end
            end
        end
        $display("test_full_memory: N=256 writes=%0d done=%b", wa_q.size(), done);
    endtask

    task automatic test_reset_mid_load();
        wa_q.delete(); wd_q.delete();
        words_q = '{32'h00500093, 32'h00A00113};
        make_frame(1'b0);
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(frame_q[i], 0);
        byte_valid = 1'b1;
        byte_data  = frame_q[4];
        #2;
        reset = 1'b0;
        #1;
        checks++; if (byte_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
            fails++; $display("FAIL midreset_port actual=%b%b/%h/%h required=00/00/00000000", byte_ready, imem_we, imem_addr, imem_wdata);
        end
        checks++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL midreset_status actual=%b%b%b required=010 (done,hold,err)", done, core_hold, error);
        end
        byte_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_frame(0);
        checks++; if (done !== 1'b1 || wa_q.size() != 2) begin fails++; $display("FAIL midreset_reload actual=done%b writes%0d required=done1 writes2", done, wa_q.size()); end
        else begin
            checks++; if (wd_q[0] !== 32'h00500093 || wa_q[1] !== 8'd1 || wd_q[1] !== 32'h00A00113) begin
                fails++; $display("FAIL midreset_words actual=%h,%h:%h required=00500093,01:00a00113", wd_q[0], wa_q[1], wd_q[1]);
            end
        end
        $display("test_reset_mid_load: reload done=%b", done);
    endtask

    task automatic test_start_mid_data();
        wa_q.delete(); wd_q.delete();
        words_q = '{32'h12345678, 32'hCAFEF00D};
        make_frame(1'b0);
        pulse_start();
        foreach (frame_q[i]) begin
            if (i == 4) start = 1'b1;
            send_byte(frame_q[i], 0);
            start = 1'b0;
        end
        checks++; if (done !== 1'b1 || wa_q.size() != 2) begin fails++; $display("FAIL middata_start actual=done%b writes%0d required=done1 writes2", done, wa_q.size()); end
        else begin
            checks++; if (wd_q[0] !== 32'h12345678 || wd_q[1] !== 32'hCAFEF00D) begin
                fails++; $display("FAIL middata_words actual=%h,%h required=12345678,cafef00d", wd_q[0], wd_q[1]);
            end
        end
        wa_q.delete(); wd_q.delete();
        words_q = '{32'hDEADBEEF};
        make_frame(1'b0);
        pulse_start();
        checks++; if (core_hold !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
            fails++; $display("FAIL restart_from_done actual=hold%b done%b ready%b required=hold1 done0 ready1", core_hold, done, byte_ready);
        end
        send_frame(0);
        checks++; if (done !== 1'b1 || wa_q.size() != 1) begin fails++; $display("FAIL restart_load actual=done%b writes%0d required=done1 writes1", done, wa_q.size()); end
        else begin
            checks++; if (wa_q[0] !== 8'd0 || wd_q[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL restart_word actual=%h:%h required=00:deadbeef", wa_q[0], wd_q[0]); end
        end
        $display("test_start_mid_data: restart done=%b", done);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        test_good_load();
        test_bad_chk();
        test_zero_count();
        test_oversize();
        test_full_memory();
        test_reset_mid_load();
        test_start_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
